// File: rtl/tx_pkg.sv
// Shared codes between the transmit controller and the row read engine:
// source-select values and the read FSM state encoding.
`default_nettype none

package tx_pkg;

  localparam logic [1:0] PIC_NONE  = 2'd0;
  localparam logic [1:0] PIC_STAR  = 2'd1;
  localparam logic [1:0] PIC_LIGHT = 2'd2;
  localparam logic [1:0] PIC_TELEM = 2'd3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/row_fifo.sv
// Synchronous FIFO with occupancy count; head word shown combinationally
// (zero while empty), so a write into an empty FIFO is visible next cycle.
`default_nettype none

module row_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_rd   = rd_en && !empty;
  // When full, the slot being read this cycle is the one written, so the pair is safe.
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

`default_nettype wire

// File: rtl/row_read_engine.sv
// Reads one image row (or a telemetry block) from memory and streams it out
// through a small buffer, never issuing more reads than the buffer can hold.
`default_nettype none

module row_read_engine
  import tx_pkg::*;
#(
  parameter int          ROW_LEN    = 2048,
  parameter int          TELEM_LEN  = 64,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [23:0] BASE_STAR  = 24'h000000,
  parameter logic [23:0] BASE_LIGHT = 24'h400000,
  parameter logic [23:0] BASE_TELEM = 24'h800000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_read,
  input  logic [10:0] row,
  input  logic [1:0]  picture_choose,
  output logic        read_done,
  output logic        rd_err,
  output logic        mem_req,
  output logic [23:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [15:0] mem_rdata,
  output logic [15:0] dout,
  output logic        dout_valid,
  output logic        dout_last,
  input  logic        dout_ready
);

  localparam int MAXLEN = (ROW_LEN > TELEM_LEN) ? ROW_LEN : TELEM_LEN;
  localparam int LW     = $clog2(MAXLEN + 1);
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(FIFO_DEPTH);

  logic [1:0]    state;
  logic [10:0]   row_lat;
  logic [1:0]    sel_lat;
  logic [LW-1:0] len_lat;
  logic [LW-1:0] col;
  logic [LW-1:0] out_col;
  logic [LW-1:0] last_col;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          err_q;
  logic          nack_q;
  logic          grant;
  logic          ret_accept;
  logic          xfer;
  logic [23:0]   base;
  logic [23:0]   row_off;

  assign last_col   = len_lat - 1'b1;
  assign grant      = mem_req && mem_gnt;
  // Returns with nothing outstanding belong to a transfer killed by reset.
  assign ret_accept = mem_rvalid && (outstanding != '0);
  assign xfer       = dout_valid && dout_ready;

  // Buffered plus in-flight words never exceed the buffer depth.
  assign mem_req = (state == ST_REQ) &&
                   (((CW + 1)'(fifo_count) + (CW + 1)'(outstanding)) < DEPTH_LIM);

  always_comb begin
    base = 24'h000000;
    case (sel_lat)
      PIC_STAR:  base = BASE_STAR;
      PIC_LIGHT: base = BASE_LIGHT;
      PIC_TELEM: base = BASE_TELEM;
      default:   base = 24'h000000;
    endcase
  end

  assign row_off  = (sel_lat == PIC_TELEM) ? 24'h000000 : 24'(row_lat) * 24'(ROW_LEN);
  assign mem_addr = base + row_off + 24'(col);

  assign dout_valid = !fifo_empty;
  assign dout_last  = dout_valid && (out_col == last_col);
  assign read_done  = (state == ST_DONE) || nack_q;
  assign rd_err     = err_q;

  row_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (ret_accept),
    .wr_data (mem_rdata),
    .rd_en   (dout_ready),
    .rd_data (dout),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      row_lat     <= '0;
      sel_lat     <= PIC_NONE;
      len_lat     <= '0;
      col         <= '0;
      out_col     <= '0;
      outstanding <= '0;
      err_q       <= 1'b0;
      nack_q      <= 1'b0;
    end else begin
      err_q  <= start_read && ((state != ST_IDLE) || (picture_choose == PIC_NONE));
      nack_q <= start_read && (state == ST_IDLE) && (picture_choose == PIC_NONE);

      case ({grant, ret_accept})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase

      if (xfer) out_col <= out_col + 1'b1;

      case (state)
        ST_IDLE: begin
          if (start_read && (picture_choose != PIC_NONE)) begin
            row_lat <= row;
            sel_lat <= picture_choose;
            len_lat <= (picture_choose == PIC_TELEM) ? LW'(TELEM_LEN) : LW'(ROW_LEN);
            col     <= '0;
            out_col <= '0;
            state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (grant) begin
            col <= col + 1'b1;
            if (col == last_col) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (xfer && dout_last) state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
